// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the RV32I datapath and the hazard/flow-control unit.
// The datapath (master) supplies decode/memory status; the unit (slave) returns enables, valids and selects.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNTW = 32
);
    logic            imem_resp;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic [4:0]      id_rd;
    logic            id_wr;
    logic            id_is_load;
    logic            dmem_req;
    logic            dmem_resp;
    logic            br_taken;

    logic            pc_load;
    logic            pc_redirect;
    logic            if_id_load;
    logic            id_exe_load;
    logic            exe_mem_load;
    logic            mem_wb_load;
    logic            v_id;
    logic            v_exe;
    logic            v_mem;
    logic            v_wb;
    logic [1:0]      fwd_a_sel;
    logic [1:0]      fwd_b_sel;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    modport master (
        output imem_resp, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr,
               id_is_load, dmem_req, dmem_resp, br_taken,
        input  pc_load, pc_redirect, if_id_load, id_exe_load, exe_mem_load, mem_wb_load,
               v_id, v_exe, v_mem, v_wb, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  imem_resp, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr,
               id_is_load, dmem_req, dmem_resp, br_taken,
        output pc_load, pc_redirect, if_id_load, id_exe_load, exe_mem_load, mem_wb_load,
               v_id, v_exe, v_mem, v_wb, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flow-control unit for the 5-stage RV32I pipeline: stage valids, destination
// shadow, stall/flush/bubble control, EXE forwarding selects and performance counters.
module pipe_hazard_ctrl #(
    parameter bit          FWD_EN   = 1'b1,
    parameter int unsigned BR_STAGE = 2,
    parameter int unsigned CNTW     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int unsigned RW = 5;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic          wr;
    } meta_t;

    logic            v_id_q, v_id_d, v_exe_q, v_exe_d, v_mem_q, v_mem_d, v_wb_q, v_wb_d;
    meta_t           exe_meta_q, exe_meta_d, mem_meta_q, mem_meta_d, wb_meta_q, wb_meta_d;
    logic            exe_is_load_q, exe_is_load_d;
    logic [RW-1:0]   exe_rs1_q, exe_rs1_d, exe_rs2_q, exe_rs2_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic exe_wr_c, mem_wr_c, wb_wr_c;
    logic hit_exe_c, hit_mem_c, hit_wb_c;
    logic mem_stall_c, br_hit_c, data_haz_c, stall_inc_c, flush_inc_c;
    logic pc_load_c, pc_redirect_c, if_id_load_c, id_exe_load_c, exe_mem_load_c, mem_wb_load_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    // A stage is a writer only when it holds a live instruction targeting a non-x0 register
    assign exe_wr_c = v_exe_q && exe_meta_q.wr && (exe_meta_q.rd != '0);
    assign mem_wr_c = v_mem_q && mem_meta_q.wr && (mem_meta_q.rd != '0);
    assign wb_wr_c  = v_wb_q  && wb_meta_q.wr  && (wb_meta_q.rd  != '0);

    assign hit_exe_c = exe_wr_c && ((bus.id_use_rs1 && (bus.id_rs1 == exe_meta_q.rd)) ||
                                    (bus.id_use_rs2 && (bus.id_rs2 == exe_meta_q.rd)));
    assign hit_mem_c = mem_wr_c && ((bus.id_use_rs1 && (bus.id_rs1 == mem_meta_q.rd)) ||
                                    (bus.id_use_rs2 && (bus.id_rs2 == mem_meta_q.rd)));
    assign hit_wb_c  = wb_wr_c  && ((bus.id_use_rs1 && (bus.id_rs1 == wb_meta_q.rd)) ||
                                    (bus.id_use_rs2 && (bus.id_rs2 == wb_meta_q.rd)));

    assign mem_stall_c = v_mem_q && bus.dmem_req && !bus.dmem_resp;
    assign br_hit_c    = bus.br_taken && ((BR_STAGE == 3) ? v_mem_q : v_exe_q);
    assign data_haz_c  = v_id_q && (FWD_EN ? ((hit_exe_c && exe_is_load_q) || hit_wb_c)
                                           : (hit_exe_c || hit_mem_c || hit_wb_c));

    // Prioritised stall/flush resolution: mem_stall > br_flush > data_haz > if_stall
    always_comb begin
        pc_load_c      = 1'b1;
        pc_redirect_c  = 1'b0;
        if_id_load_c   = 1'b1;
        id_exe_load_c  = 1'b1;
        exe_mem_load_c = 1'b1;
        mem_wb_load_c  = 1'b1;
        v_id_d         = bus.imem_resp;
        v_exe_d        = v_id_q;
        v_mem_d        = v_exe_q;
        v_wb_d         = v_mem_q;
        stall_inc_c    = 1'b0;
        flush_inc_c    = 1'b0;
        if (mem_stall_c) begin
            pc_load_c      = 1'b0;
            if_id_load_c   = 1'b0;
            id_exe_load_c  = 1'b0;
            exe_mem_load_c = 1'b0;
            v_id_d         = v_id_q;
            v_exe_d        = v_exe_q;
            v_mem_d        = v_mem_q;
            v_wb_d         = 1'b0;
            stall_inc_c    = 1'b1;
        end else if (br_hit_c) begin
            pc_redirect_c = 1'b1;
            v_id_d        = 1'b0;
            v_exe_d       = 1'b0;
            if (BR_STAGE == 3) begin
                v_mem_d = 1'b0;
            end
            flush_inc_c = 1'b1;
        end else if (data_haz_c) begin
            pc_load_c    = 1'b0;
            if_id_load_c = 1'b0;
            v_id_d       = v_id_q;
            v_exe_d      = 1'b0;
            stall_inc_c  = 1'b1;
        end else if (!bus.imem_resp) begin
            pc_load_c   = 1'b0;
            stall_inc_c = 1'b1;
        end
    end

    // Shadow metadata follows the pipeline-register load enables
    always_comb begin
        exe_meta_d    = exe_meta_q;
        exe_is_load_d = exe_is_load_q;
        exe_rs1_d     = exe_rs1_q;
        exe_rs2_d     = exe_rs2_q;
        mem_meta_d    = mem_meta_q;
        wb_meta_d     = wb_meta_q;
        if (id_exe_load_c) begin
            exe_meta_d    = '{rd: bus.id_rd, wr: bus.id_wr};
            exe_is_load_d = bus.id_is_load;
            exe_rs1_d     = bus.id_rs1;
            exe_rs2_d     = bus.id_rs2;
        end
        if (exe_mem_load_c) begin
            mem_meta_d = exe_meta_q;
        end
        if (mem_wb_load_c) begin
            wb_meta_d = mem_meta_q;
        end
    end

    // Saturating counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
        if (flush_inc_c && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNTW'(1);
        end
    end

    // EXE operand forwarding, MEM result preferred over WB
    always_comb begin
        fwd_a_c = 2'd0;
        fwd_b_c = 2'd0;
        if (FWD_EN) begin
            if (mem_wr_c && (mem_meta_q.rd == exe_rs1_q)) begin
                fwd_a_c = 2'd1;
            end else if (wb_wr_c && (wb_meta_q.rd == exe_rs1_q)) begin
                fwd_a_c = 2'd2;
            end
            if (mem_wr_c && (mem_meta_q.rd == exe_rs2_q)) begin
                fwd_b_c = 2'd1;
            end else if (wb_wr_c && (wb_meta_q.rd == exe_rs2_q)) begin
                fwd_b_c = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_id_q        <= 1'b0;
            v_exe_q       <= 1'b0;
            v_mem_q       <= 1'b0;
            v_wb_q        <= 1'b0;
            exe_meta_q    <= '0;
            mem_meta_q    <= '0;
            wb_meta_q     <= '0;
            exe_is_load_q <= 1'b0;
            exe_rs1_q     <= '0;
            exe_rs2_q     <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            v_id_q        <= v_id_d;
            v_exe_q       <= v_exe_d;
            v_mem_q       <= v_mem_d;
            v_wb_q        <= v_wb_d;
            exe_meta_q    <= exe_meta_d;
            mem_meta_q    <= mem_meta_d;
            wb_meta_q     <= wb_meta_d;
            exe_is_load_q <= exe_is_load_d;
            exe_rs1_q     <= exe_rs1_d;
            exe_rs2_q     <= exe_rs2_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign bus.pc_load      = pc_load_c;
    assign bus.pc_redirect  = pc_redirect_c;
    assign bus.if_id_load   = if_id_load_c;
    assign bus.id_exe_load  = id_exe_load_c;
    assign bus.exe_mem_load = exe_mem_load_c;
    assign bus.mem_wb_load  = mem_wb_load_c;
    assign bus.v_id         = v_id_q;
    assign bus.v_exe        = v_exe_q;
    assign bus.v_mem        = v_mem_q;
    assign bus.v_wb         = v_wb_q;
    assign bus.fwd_a_sel    = fwd_a_c;
    assign bus.fwd_b_sel    = fwd_b_c;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three configurations (forwarding/EXE branch, forwarding/MEM
// branch with 4-bit counters, no forwarding) share one stimulus stream.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_resp, id_use_rs1, id_use_rs2, id_wr, id_is_load, dmem_req, dmem_resp, br_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNTW(32)) if_a ();
    pipe_hazard_ctrl_if #(.CNTW(4))  if_b ();
    pipe_hazard_ctrl_if #(.CNTW(32)) if_c ();

    assign if_a.imem_resp = imem_resp;   assign if_b.imem_resp = imem_resp;   assign if_c.imem_resp = imem_resp;
    assign if_a.id_rs1 = id_rs1;         assign if_b.id_rs1 = id_rs1;         assign if_c.id_rs1 = id_rs1;
    assign if_a.id_rs2 = id_rs2;         assign if_b.id_rs2 = id_rs2;         assign if_c.id_rs2 = id_rs2;
    assign if_a.id_use_rs1 = id_use_rs1; assign if_b.id_use_rs1 = id_use_rs1; assign if_c.id_use_rs1 = id_use_rs1;
    assign if_a.id_use_rs2 = id_use_rs2; assign if_b.id_use_rs2 = id_use_rs2; assign if_c.id_use_rs2 = id_use_rs2;
    assign if_a.id_rd = id_rd;           assign if_b.id_rd = id_rd;           assign if_c.id_rd = id_rd;
    assign if_a.id_wr = id_wr;           assign if_b.id_wr = id_wr;           assign if_c.id_wr = id_wr;
    assign if_a.id_is_load = id_is_load; assign if_b.id_is_load = id_is_load; assign if_c.id_is_load = id_is_load;
    assign if_a.dmem_req = dmem_req;     assign if_b.dmem_req = dmem_req;     assign if_c.dmem_req = dmem_req;
    assign if_a.dmem_resp = dmem_resp;   assign if_b.dmem_resp = dmem_resp;   assign if_c.dmem_resp = dmem_resp;
    assign if_a.br_taken = br_taken;     assign if_b.br_taken = br_taken;     assign if_c.br_taken = br_taken;

    pipe_hazard_ctrl #(.FWD_EN(1'b1), .BR_STAGE(2), .CNTW(32)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    pipe_hazard_ctrl #(.FWD_EN(1'b1), .BR_STAGE(3), .CNTW(4))  u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    pipe_hazard_ctrl #(.FWD_EN(1'b0), .BR_STAGE(2), .CNTW(32)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        imem_resp = 1'b1; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_rd = 5'd0; id_wr = 1'b0; id_is_load = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b1;
        br_taken = 1'b0;
    endtask

    task automatic set_id(input logic u1, input logic [4:0] r1, input logic u2, input logic [4:0] r2,
                          input logic wr, input logic [4:0] rd, input logic ld);
        id_use_rs1 = u1; id_rs1 = r1; id_use_rs2 = u2; id_rs2 = r2;
        id_wr = wr; id_rd = rd; id_is_load = ld;
    endtask

    task automatic do_reset();
        idle();
        tick();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] v;
        v = {if_a.v_id, if_a.v_exe, if_a.v_mem, if_a.v_wb};
        n_chk++;
        if (v !== 4'b0000) begin n_fail++; $display("FAIL reset_valids: got %b want 0000", v); end
        n_chk++;
        if ({if_a.stall_cnt, if_a.flush_cnt} !== 64'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", if_a.stall_cnt, if_a.flush_cnt);
        end
        n_chk++;
        if ({if_a.pc_redirect, if_a.fwd_a_sel, if_a.fwd_b_sel} !== 5'b0) begin
            n_fail++; $display("FAIL reset_redirect_fwd: got %b want 00000",
                               {if_a.pc_redirect, if_a.fwd_a_sel, if_a.fwd_b_sel});
        end
        #3;
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (if_a.v_id !== 1'b1) begin n_fail++; $display("FAIL first_fetch_v_id: got %b want 1", if_a.v_id); end
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] v;
        do_reset();
        repeat (4) tick();
        v = {if_a.v_id, if_a.v_exe, if_a.v_mem, if_a.v_wb};
        n_chk++;
        if (v !== 4'b1111) begin n_fail++; $display("FAIL fill_valids: got %b want 1111", v); end
        imem_resp = 1'b0;
        tick();
        v = {if_a.v_id, if_a.v_exe, if_a.v_mem, if_a.v_wb};
        n_chk++;
        if (v !== 4'b0111 || if_a.stall_cnt !== 32'd1) begin
            n_fail++; $display("FAIL if_stall_bubble: got v=%b cnt=%0d want v=0111 cnt=1", v, if_a.stall_cnt);
        end
        imem_resp = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        v = {if_a.v_id, if_a.v_exe, if_a.v_mem, if_a.v_wb};
        n_chk++;
        if (v !== 4'b0000 || if_a.stall_cnt !== 32'd0 || if_a.flush_cnt !== 32'd0) begin
            n_fail++; $display("FAIL async_reset: got v=%b cnt=%0d/%0d want v=0000 cnt=0/0",
                               v, if_a.stall_cnt, if_a.flush_cnt);
        end
        rst_n = 1'b1;
        tick();
        n_chk++;
        if ({if_a.v_id, if_a.v_wb} !== 2'b10) begin
            n_fail++; $display("FAIL post_reset_c1: got v_id,v_wb=%b want 10", {if_a.v_id, if_a.v_wb});
        end
        tick();
        n_chk++;
        if (if_a.v_wb !== 1'b0) begin n_fail++; $display("FAIL post_reset_c2_v_wb: got %b want 0", if_a.v_wb); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1);
        tick();
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b0);
        dmem_req = 1'b1;
        #1;
        n_chk++;
        if ({if_a.pc_load, if_a.if_id_load, if_a.id_exe_load} !== 3'b001) begin
            n_fail++; $display("FAIL load_use_enables: got %b want 001",
                               {if_a.pc_load, if_a.if_id_load, if_a.id_exe_load});
        end
        tick();
        n_chk++;
        if ({if_a.v_exe, if_a.v_mem} !== 2'b01 || if_a.stall_cnt !== 32'd1) begin
            n_fail++; $display("FAIL load_use_bubble: got exe,mem=%b cnt=%0d want 01 cnt=1",
                               {if_a.v_exe, if_a.v_mem}, if_a.stall_cnt);
        end
        tick();
        n_chk++;
        if (if_a.v_exe !== 1'b1 || if_a.fwd_a_sel !== 2'd2 || if_a.fwd_b_sel !== 2'd2 || if_a.stall_cnt !== 32'd1) begin
            n_fail++; $display("FAIL load_use_fwd: got v_exe=%b a=%0d b=%0d cnt=%0d want 1 2 2 1",
                               if_a.v_exe, if_a.fwd_a_sel, if_a.fwd_b_sel, if_a.stall_cnt);
        end
        n_chk++;
        if (if_c.v_exe !== 1'b0 || if_c.fwd_a_sel !== 2'd0 || if_c.stall_cnt !== 32'd2) begin
            n_fail++; $display("FAIL nofwd_load_use: got v_exe=%b a=%0d cnt=%0d want 0 0 2",
                               if_c.v_exe, if_c.fwd_a_sel, if_c.stall_cnt);
        end
        idle();
    endtask

    task automatic test_branch_flush();
        do_reset();
        repeat (4) tick();
        br_taken = 1'b1;
        #1;
        n_chk++;
        if ({if_a.pc_redirect, if_a.pc_load, if_b.pc_redirect, if_b.pc_load} !== 4'b1111) begin
            n_fail++; $display("FAIL br_redirect: got %b want 1111",
                               {if_a.pc_redirect, if_a.pc_load, if_b.pc_redirect, if_b.pc_load});
        end
        tick();
        br_taken = 1'b0;
        #1;
        n_chk++;
        if ({if_a.v_id, if_a.v_exe, if_a.v_mem, if_a.v_wb} !== 4'b0011 || if_a.flush_cnt !== 32'd1 ||
            if_a.pc_redirect !== 1'b0) begin
            n_fail++; $display("FAIL br2_flush: got v=%b cnt=%0d redir=%b want 0011 1 0",
                               {if_a.v_id, if_a.v_exe, if_a.v_mem, if_a.v_wb}, if_a.flush_cnt, if_a.pc_redirect);
        end
        n_chk++;
        if ({if_b.v_id, if_b.v_exe, if_b.v_mem, if_b.v_wb} !== 4'b0001 || if_b.flush_cnt !== 4'd1) begin
            n_fail++; $display("FAIL br3_flush: got v=%b cnt=%0d want 0001 1",
                               {if_b.v_id, if_b.v_exe, if_b.v_mem, if_b.v_wb}, if_b.flush_cnt);
        end
        tick();
        n_chk++;
        if ({if_a.v_id, if_a.v_exe} !== 2'b10 || if_b.v_mem !== 1'b0) begin
            n_fail++; $display("FAIL br_refill_c1: got a id,exe=%b b mem=%b want 10 0",
                               {if_a.v_id, if_a.v_exe}, if_b.v_mem);
        end
        tick();
        n_chk++;
        if (if_a.v_exe !== 1'b1 || {if_b.v_exe, if_b.v_mem} !== 2'b10) begin
            n_fail++; $display("FAIL br_refill_c2: got a exe=%b b exe,mem=%b want 1 10",
                               if_a.v_exe, {if_b.v_exe, if_b.v_mem});
        end
    endtask

    task automatic test_dmem_wait();
        do_reset();
        repeat (4) tick();
        dmem_req = 1'b1;
        dmem_resp = 1'b0;
        br_taken = 1'b1;
        #1;
        n_chk++;
        if ({if_a.pc_load, if_a.pc_redirect, if_a.if_id_load, if_a.id_exe_load, if_a.exe_mem_load,
             if_a.mem_wb_load} !== 6'b000001) begin
            n_fail++; $display("FAIL dmem_wait_enables: got %b want 000001",
                               {if_a.pc_load, if_a.pc_redirect, if_a.if_id_load, if_a.id_exe_load,
                                if_a.exe_mem_load, if_a.mem_wb_load});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if ({if_a.v_id, if_a.v_exe, if_a.v_mem, if_a.v_wb} !== 4'b1110) begin
                n_fail++; $display("FAIL dmem_wait_freeze[%0d]: got %b want 1110", i,
                                   {if_a.v_id, if_a.v_exe, if_a.v_mem, if_a.v_wb});
            end
        end
        n_chk++;
        if (if_a.stall_cnt !== 32'd3 || if_a.flush_cnt !== 32'd0) begin
            n_fail++; $display("FAIL dmem_wait_counts: got %0d/%0d want 3/0", if_a.stall_cnt, if_a.flush_cnt);
        end
        dmem_resp = 1'b1;
        #1;
        n_chk++;
        if (if_a.pc_redirect !== 1'b1) begin
            n_fail++; $display("FAIL dmem_release_redirect: got %b want 1", if_a.pc_redirect);
        end
        tick();
        br_taken = 1'b0;
        dmem_req = 1'b0;
        #1;
        n_chk++;
        if ({if_a.v_id, if_a.v_exe, if_a.v_mem, if_a.v_wb} !== 4'b0011 || if_a.flush_cnt !== 32'd1 ||
            if_a.stall_cnt !== 32'd3) begin
            n_fail++; $display("FAIL dmem_release_flush: got v=%b cnt=%0d/%0d want 0011 3/1",
                               {if_a.v_id, if_a.v_exe, if_a.v_mem, if_a.v_wb}, if_a.stall_cnt, if_a.flush_cnt);
        end
    endtask

    task automatic test_fwd_priority_x0();
        do_reset();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
        tick();
        tick();
        tick();
        set_id(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        n_chk++;
        if ({if_a.pc_load, if_c.pc_load} !== 2'b10) begin
            n_fail++; $display("FAIL x7_reader_stall: got fwd,nofwd pc_load=%b want 10", {if_a.pc_load, if_c.pc_load});
        end
        tick();
        n_chk++;
        if (if_a.fwd_a_sel !== 2'd1 || if_a.fwd_b_sel !== 2'd0) begin
            n_fail++; $display("FAIL fwd_mem_priority: got a=%0d b=%0d want 1 0", if_a.fwd_a_sel, if_a.fwd_b_sel);
        end
        n_chk++;
        if (if_c.fwd_a_sel !== 2'd0 || if_c.v_exe !== 1'b0) begin
            n_fail++; $display("FAIL nofwd_sel: got a=%0d v_exe=%b want 0 0", if_c.fwd_a_sel, if_c.v_exe);
        end
        set_id(1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
        #1;
        n_chk++;
        if (if_a.pc_load !== 1'b0) begin
            n_fail++; $display("FAIL wb_read_stall: got pc_load=%b want 0", if_a.pc_load);
        end
        // A load to x0 followed by a reader of x0 must neither stall nor forward
        do_reset();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        tick();
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
        #1;
        n_chk++;
        if ({if_a.pc_load, if_c.pc_load} !== 2'b11) begin
            n_fail++; $display("FAIL x0_no_stall: got pc_load=%b want 11", {if_a.pc_load, if_c.pc_load});
        end
        tick();
        n_chk++;
        if ({if_a.fwd_a_sel, if_a.fwd_b_sel} !== 4'd0 || if_a.v_exe !== 1'b1 || if_c.v_exe !== 1'b1 ||
            if_a.stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL x0_no_fwd: got a=%0d b=%0d v_exe=%b%b cnt=%0d want 0 0 11 0",
                               if_a.fwd_a_sel, if_a.fwd_b_sel, if_a.v_exe, if_c.v_exe, if_a.stall_cnt);
        end
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        imem_resp = 1'b0;
        repeat (15) tick();
        n_chk++;
        if (if_b.stall_cnt !== 4'd15) begin
            n_fail++; $display("FAIL sat_at_15: got %0d want 15", if_b.stall_cnt);
        end
        repeat (5) tick();
        n_chk++;
        if (if_b.stall_cnt !== 4'd15 || if_a.stall_cnt !== 32'd20) begin
            n_fail++; $display("FAIL sat_hold: got b=%0d a=%0d want 15 20", if_b.stall_cnt, if_a.stall_cnt);
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #1;
        test_reset();
        test_reset_mid_run();
        test_load_use();
        test_branch_flush();
        test_dmem_wait();
        test_fwd_priority_x0();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
